// File: rtl/mc_div_sgn.sv
// Multicycle radix-2 restoring divider, signed/unsigned, with divide-by-zero detect and abort.
// Latency: W_RESULT pulses W+2 cycles after GO is accepted, or 2 cycles when B==0.
// No backpressure: GO is ignored while BUSY; KILL drops the operation in flight.
module mc_div_sgn #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         GO,
  input  logic         SIGNED,
  input  logic         KILL,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         BUSY,
  output logic         W_RESULT,
  output logic         DIV0,
  output logic [W-1:0] QUOT,
  output logic [W-1:0] REM
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;        // partial remainder
  logic [W-1:0]  quo_q, quo_d;        // dividend shifting out, quotient shifting in
  logic [W-1:0]  dvs_q, dvs_d;        // divisor magnitude
  logic [W-1:0]  a_raw_q, a_raw_d;    // dividend as sampled, returned on divide-by-zero
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          dz_q, dz_d;
  logic          wres_q, wres_d;
  logic          div0_q, div0_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  res_rem_q, res_rem_d;

  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    rem_sh, diff;

  // Next-state, datapath iteration and result sign correction
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    a_raw_d   = a_raw_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    wres_d    = 1'b0;
    div0_d    = div0_q;
    quot_d    = quot_q;
    res_rem_d = res_rem_q;

    // Magnitudes fit W unsigned bits, so negating MIN yields 2^(W-1) exactly
    a_mag  = (SIGNED && A[W-1]) ? -A : A;
    b_mag  = (SIGNED && B[W-1]) ? -B : B;
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = rem_sh - {1'b0, dvs_q};

    case (state_q)
      S_IDLE: begin
        if (GO && !KILL) begin
          a_raw_d = A;
          dvs_d   = b_mag;
          rem_d   = '0;
          quo_d   = a_mag;
          qneg_d  = SIGNED & (A[W-1] ^ B[W-1]);
          rneg_d  = SIGNED & A[W-1];
          dz_d    = (B == '0);
          cnt_d   = '0;
          state_d = (B == '0) ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (!diff[W]) begin
          rem_d = diff[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        wres_d  = 1'b1;
        div0_d  = dz_q;
        if (dz_q) begin
          quot_d    = '1;
          res_rem_d = a_raw_q;
        end else begin
          quot_d    = qneg_q ? -quo_q : quo_q;
          res_rem_d = rneg_q ? -rem_q : rem_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything but reset: no pulse, results untouched
    if (KILL && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      wres_d    = 1'b0;
      div0_d    = div0_q;
      quot_d    = quot_q;
      res_rem_d = res_rem_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      a_raw_q   <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      wres_q    <= 1'b0;
      div0_q    <= 1'b0;
      quot_q    <= '0;
      res_rem_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      a_raw_q   <= a_raw_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      wres_q    <= wres_d;
      div0_q    <= div0_d;
      quot_q    <= quot_d;
      res_rem_q <= res_rem_d;
    end
  end

  assign BUSY     = (state_q != S_IDLE);
  assign W_RESULT = wres_q;
  assign DIV0     = div0_q;
  assign QUOT     = quot_q;
  assign REM      = res_rem_q;

endmodule

// File: tb/tb_mc_div_sgn.sv
// Bench for mc_div_sgn: directed corner cases, abort/reset/back-to-back timing, random vectors
// against an arithmetic reference model.
module tb_mc_div_sgn;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic         CLK = 1'b0;
  logic         RESET, GO, SIGNED, KILL;
  logic [W-1:0] A, B;
  logic         BUSY, W_RESULT, DIV0;
  logic [W-1:0] QUOT, REM;

  int ncmp  = 0;
  int nfail = 0;

  always #5 CLK = ~CLK;

  mc_div_sgn #(.W(W)) dut (
    .CLK(CLK), .RESET(RESET), .GO(GO), .SIGNED(SIGNED), .KILL(KILL),
    .A(A), .B(B), .BUSY(BUSY), .W_RESULT(W_RESULT), .DIV0(DIV0),
    .QUOT(QUOT), .REM(REM)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; returns at the falling edge where outputs are sampled and inputs driven
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reference: plain truncating / and % on 64-bit integers
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic d);
    longint na, nb;
    if (b == 0) begin
      q = '1; r = a; d = 1'b1;
    end else begin
      d = 1'b0;
      if (s) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'b0, a});
        nb = longint'({32'b0, b});
      end
      q = 32'(na / nb);
      r = 32'(na % nb);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    A = a; B = b; SIGNED = s; GO = 1'b1;
  endtask

  // Called in cycle 0; returns at the sample point of the W_RESULT cycle
  task automatic finish_op(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ed);
    int done;
    done = ed ? 2 : W + 2;
    step();
    GO = 1'b0;
    A = $urandom; B = $urandom; SIGNED = 1'($urandom_range(0, 1));
    for (int c = 1; c <= done; c++) begin
      chk({tag, " busy"}, BUSY, (c < done));
      chk({tag, " w_result"}, W_RESULT, (c == done));
      if (c < done) step();
    end
    chk({tag, " quot"}, QUOT, eq);
    chk({tag, " rem"}, REM, er);
    chk({tag, " div0"}, DIV0, ed);
  endtask

  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                    input logic ed);
    step();
    start_op(a, b, s);
    finish_op(tag, eq, er, ed);
  endtask

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic         rs, md, seen;
    int           sel;

    RESET = 1'b1; GO = 1'b0; KILL = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
    step(); step(); step();
    chk("rst busy", BUSY, 1'b0);
    chk("rst w_result", W_RESULT, 1'b0);
    chk("rst div0", DIV0, 1'b0);
    chk("rst quot", QUOT, 0);
    chk("rst rem", REM, 0);
    RESET = 1'b0;

    op("u100/7", 100, 7, 1'b0, 14, 2, 1'b0);
    op("s-7/2", -32'sd7, 2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    op("s7/-2", 7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 1, 1'b0);
    op("s-7/-2", -32'sd7, -32'sd2, 1'b1, 3, 32'hFFFF_FFFF, 1'b0);
    op("u_div0", 32'h1234, 0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    op("s_div0", 32'h1234, 0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    op("s_neg_div0", 32'hFFFF_FFF0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1);
    op("u9/3_clr", 9, 3, 1'b0, 3, 0, 1'b0);
    op("s_min/-1", MIN, 32'hFFFF_FFFF, 1'b1, MIN, 0, 1'b0);
    op("u_min/ffff", MIN, 32'hFFFF_FFFF, 1'b0, 0, MIN, 1'b0);
    op("s_min/2", MIN, 2, 1'b1, 32'hC000_0000, 0, 1'b0);
    op("u9/3_pre", 9, 3, 1'b0, 3, 0, 1'b0);

    // Abort in cycle 10 with ignored GO pulses in cycles 5..9
    step();
    start_op(100, 7, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      step();
      GO   = (c >= 5 && c <= 9);
      A    = $urandom;
      B    = $urandom;
      KILL = (c == 10);
    end
    step();
    KILL = 1'b0; GO = 1'b0;
    chk("kill busy_c11", BUSY, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (W_RESULT || BUSY) seen = 1'b1;
      step();
    end
    chk("kill no_activity", seen, 1'b0);
    chk("kill quot_hold", QUOT, 3);
    chk("kill rem_hold", REM, 0);
    chk("kill div0_hold", DIV0, 1'b0);

    // Back-to-back: second GO issued in the W_RESULT cycle of the first
    step();
    start_op(100, 7, 1'b0);
    finish_op("b2b_first", 14, 2, 1'b0);
    start_op(50, 5, 1'b0);
    finish_op("b2b_second", 10, 0, 1'b0);

    // Synchronous reset in cycle 12 of an operation
    step();
    start_op(1000, 3, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      step();
      GO = 1'b0;
      RESET = (c == 12);
    end
    step();
    RESET = 1'b0;
    chk("mid_rst busy", BUSY, 1'b0);
    chk("mid_rst w_result", W_RESULT, 1'b0);
    chk("mid_rst quot", QUOT, 0);
    chk("mid_rst rem", REM, 0);
    chk("mid_rst div0", DIV0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (W_RESULT) seen = 1'b1;
      step();
    end
    chk("mid_rst no_pulse", seen, 1'b0);

    // GO together with KILL while idle is not accepted
    step();
    start_op(100, 7, 1'b0);
    KILL = 1'b1;
    step();
    GO = 1'b0; KILL = 1'b0;
    chk("go_kill busy", BUSY, 1'b0);

    // Random vectors against the reference model
    for (int i = 0; i < 1200; i++) begin
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      rs  = 1'($urandom_range(0, 1));
      case (sel)
        0: rb = '0;
        1: begin ra = MIN; rb = '1; end
        2: rb = 32'($urandom_range(1, 15));
        3: begin ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(1, 17)); end
        4: begin ra = -32'($urandom_range(0, 255)); rb = -32'($urandom_range(1, 17)); end
        5: ra = MIN;
        default: ;
      endcase
      model(ra, rb, rs, mq, mr, md);
      op("rand", ra, rb, rs, mq, mr, md);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
